// File: rtl/unidade_ponto_flt_param_if.sv
// ---------------------------------------------------------------------------
// unidade_ponto_flt_param_if
// Handshake and data bundle between the integer core (master) and the
// floating-point unit (slave).
//   start  master->slave  launch an operation on a/b/op
//   op     master->slave  00 add, 01 sub, 10 mul, 11 reserved
//   a, b   master->slave  operands, W = 1+EXP_W+MAN_W bits
//   s      slave->master  result, held from one finish to the next
//   finish slave->master  one-cycle completion pulse
//   busy   slave->master  operation in flight
//   flags  slave->master  {invalid, overflow, underflow}
// ---------------------------------------------------------------------------
interface unidade_ponto_flt_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] s;
  logic         finish;
  logic         busy;
  logic [2:0]   flags;

  modport master (
    output start, op, a, b,
    input  s, finish, busy, flags
  );

  modport slave (
    input  start, op, a, b,
    output s, finish, busy, flags
  );
endinterface

// File: rtl/unidade_ponto_flt_param.sv
// ---------------------------------------------------------------------------
// unidade_ponto_flt_param
// Multi-cycle floating-point unit (add, sub, mul) for IEEE-754-style operands
// with configurable exponent/mantissa widths. Subnormals are flushed to zero.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    unidade_ponto_flt_param_if.slave (start/op/a/b in, s/finish/busy/flags out)
// Build option:
//   FPU_ROUND_NEAREST_EN  defined -> round to nearest even, otherwise truncate.
//   Both builds spend one cycle in ROUND, so latency does not change.
// ---------------------------------------------------------------------------
module unidade_ponto_flt_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  unidade_ponto_flt_param_if.slave  bus
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int MW    = MAN_W + 4;        // hidden + fraction + guard/round/sticky
  localparam int AW    = MAN_W + 5;        // MW plus a carry bit on top
  localparam int PW    = 2 * (MAN_W + 1);  // full product width
  localparam int XW    = EXP_W + 2;        // signed working exponent
  localparam int CNT_W = $clog2(MAN_W + 4);
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;

  localparam logic signed [XW-1:0] BIAS_X   = XW'(BIAS);
  localparam logic signed [XW-1:0] EXP_TOP  = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EXP_ZERO = '0;
  localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [W-1:0]         QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, MUL, NORM, ROUND, DONE
  } state_t;

  state_t state, state_n;

  logic [W-1:0]           a_r, b_r;
  logic [1:0]             op_r;
  logic                   sign_r;
  logic                   eff_sub;
  logic signed [XW-1:0]   exp_r;
  logic [MW-1:0]          m_big, m_small;
  logic [CNT_W-1:0]       cnt;
  logic [PW-1:0]          mcand, prod;
  logic [MAN_W:0]         mplier;
  logic [AW-1:0]          acc;
  logic [W-1:0]           s_r;
  logic [2:0]             flags_r;

  // Field split of the captured operands; b's sign is flipped for subtract
  // so the rest of the datapath only ever adds.
  logic                   sa, sb;
  logic [EXP_W-1:0]       ea, eb;
  logic [MAN_W-1:0]       fa, fb;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    sa     = a_r[W-1];
    sb     = b_r[W-1] ^ (op_r == 2'b01);
    ea     = a_r[W-2:MAN_W];
    eb     = b_r[W-2:MAN_W];
    fa     = a_r[MAN_W-1:0];
    fb     = b_r[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == '1) && (fa == '0);
    b_inf  = (eb == '1) && (fb == '0);
    a_nan  = (ea == '1) && (fa != '0);
    b_nan  = (eb == '1) && (fb != '0);
  end

  // Operands that bypass the arithmetic: NaN, infinity, zero (including
  // flushed subnormals) and the reserved opcode.
  logic                   special;
  logic [W-1:0]           sp_s;
  logic [2:0]             sp_flags;

  always_comb begin
    special  = 1'b0;
    sp_s     = QNAN;
    sp_flags = 3'b000;
    if (op_r == 2'b11 || a_nan || b_nan) begin
      special  = 1'b1;
      sp_flags = 3'b100;
    end else if (op_r == 2'b10) begin
      if ((a_inf && b_zero) || (a_zero && b_inf)) begin
        special  = 1'b1;
        sp_flags = 3'b100;
      end else if (a_inf || b_inf) begin
        special = 1'b1;
        sp_s    = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        special = 1'b1;
        sp_s    = {sa ^ sb, {(W-1){1'b0}}};
      end
    end else begin
      if (a_inf && b_inf) begin
        special = 1'b1;
        if (sa != sb) begin
          sp_flags = 3'b100;
        end else begin
          sp_s = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
      end else if (a_inf) begin
        special = 1'b1;
        sp_s    = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
        special = 1'b1;
        sp_s    = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
        // -0 + -0 stays negative, any other mix of zeros gives +0
        special = 1'b1;
        sp_s    = {sa & sb, {(W-1){1'b0}}};
      end else if (a_zero) begin
        special = 1'b1;
        sp_s    = {sb, b_r[W-2:0]};
      end else if (b_zero) begin
        special = 1'b1;
        sp_s    = a_r;
      end
    end
  end

  // Add/sub ordering: the operand with the larger magnitude is kept as-is and
  // the other is aligned to it, so the subtraction can never go negative.
  logic                   a_big;
  logic [EXP_W-1:0]       e_big;
  logic [EXP_W-1:0]       diff;
  logic [CNT_W-1:0]       align_cnt;

  always_comb begin
    a_big     = (a_r[W-2:0] >= b_r[W-2:0]);
    e_big     = a_big ? ea : eb;
    diff      = a_big ? (ea - eb) : (eb - ea);
    // Beyond MAN_W+3 shifts every bit already sits in sticky, so cap there.
    align_cnt = (int'(diff) > MAN_W + 3) ? CNT_W'(MAN_W + 3) : CNT_W'(diff);
  end

  // Arithmetic helpers for the ADD and MUL states.
  logic [AW-1:0]          add_sum;
  logic [PW-1:0]          prod_next;
  logic [AW-1:0]          prod_acc;

  always_comb begin
    add_sum   = eff_sub ? ({1'b0, m_big} - {1'b0, m_small})
                        : ({1'b0, m_big} + {1'b0, m_small});
    prod_next = prod + (mplier[0] ? mcand : '0);
    // Top MAN_W+4 product bits line up with the carry/hidden/fraction/G/R
    // layout; everything below folds into sticky.
    prod_acc  = {prod_next[PW-1:MAN_W-2], |prod_next[MAN_W-3:0]};
  end

  // Rounding and final range checks on the normalised mantissa.
  logic                   round_up;
  logic [MAN_W+1:0]       rounded;
  logic signed [XW-1:0]   exp_rnd;
  logic [MAN_W-1:0]       frac_rnd;
  logic [W-1:0]           rnd_s;
  logic [2:0]             rnd_flags;

  always_comb begin
`ifdef FPU_ROUND_NEAREST_EN
    round_up = acc[2] & (acc[1] | acc[0] | acc[3]);
`else
    round_up = 1'b0;
`endif
    rounded   = {1'b0, acc[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};
    // A carry out of the rounder leaves 10.000..0: bump the exponent.
    exp_rnd   = rounded[MAN_W+1] ? (exp_r + EXP_ONE) : exp_r;
    frac_rnd  = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    rnd_s     = {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
    rnd_flags = 3'b000;
    if (acc == '0) begin
      rnd_s = '0;
    end else if (exp_rnd <= EXP_ZERO) begin
      rnd_s     = {sign_r, {(W-1){1'b0}}};
      rnd_flags = 3'b001;
    end else if (exp_rnd >= EXP_TOP) begin
      rnd_s     = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_flags = 3'b010;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic. Only IDLE listens to start, which is what makes start
  // during busy or during the finish cycle a no-op.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start) state_n = UNPACK;
      UNPACK: begin
        if (special)              state_n = DONE;
        else if (op_r == 2'b10)   state_n = MUL;
        else                      state_n = ALIGN;
      end
      ALIGN:   if (cnt == '0) state_n = ADD;
      ADD:     state_n = NORM;
      MUL:     if (cnt == CNT_ONE) state_n = NORM;
      NORM:    if (acc == '0 || (!acc[AW-1] && acc[AW-2])) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: each state advances its own piece of the operation. The result
  // register is written only on the edge into DONE, so s and flags hold
  // between finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      sign_r  <= 1'b0;
      eff_sub <= 1'b0;
      exp_r   <= '0;
      m_big   <= '0;
      m_small <= '0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      prod    <= '0;
      acc     <= '0;
      s_r     <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r  <= bus.a;
            b_r  <= bus.b;
            op_r <= bus.op;
          end
        end
        UNPACK: begin
          if (special) begin
            s_r     <= sp_s;
            flags_r <= sp_flags;
          end else if (op_r == 2'b10) begin
            sign_r <= sa ^ sb;
            exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
            mcand  <= {{(MAN_W+1){1'b0}}, 1'b1, fa};
            mplier <= {1'b1, fb};
            prod   <= '0;
            cnt    <= CNT_W'(MAN_W + 1);
          end else begin
            sign_r  <= a_big ? sa : sb;
            eff_sub <= sa ^ sb;
            exp_r   <= $signed({2'b00, e_big});
            m_big   <= a_big ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
            m_small <= a_big ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
            cnt     <= align_cnt;
          end
        end
        ALIGN: begin
          if (cnt != '0) begin
            m_small <= {1'b0, m_small[MW-1:2], m_small[1] | m_small[0]};
            cnt     <= cnt - CNT_ONE;
          end
        end
        ADD: begin
          acc <= add_sum;
        end
        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) acc <= prod_acc;
        end
        NORM: begin
          if (acc[AW-1]) begin
            acc   <= {1'b0, acc[AW-1:2], acc[1] | acc[0]};
            exp_r <= exp_r + EXP_ONE;
          end else if (!acc[AW-2] && acc != '0) begin
            acc   <= acc << 1;
            exp_r <= exp_r - EXP_ONE;
          end
        end
        ROUND: begin
          s_r     <= rnd_s;
          flags_r <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign bus.s      = s_r;
  assign bus.flags  = flags_r;
  assign bus.finish = (state == DONE);
  assign bus.busy   = (state != IDLE);

endmodule
